// File: rtl/selecao_contador_bebida.sv
`default_nettype none
// ============================================================================
// Module      : selecao_contador_bebida
// Description : Front-panel front end for the S2 drink-choice display.
//               Both raw buttons are synchronised (two flops) and debounced,
//               and their rising debounced edges drive an
//               idle / select / confirm state machine. It produces the 2-bit
//               selection count shown by the S2 decoder, plus a latched
//               confirmed code with a one-cycle strobe for the brewing
//               controller.
//
// Parameters  : DEBOUNCE_CICLOS  stable samples needed to change a debounced
//                                level (2..255)
//               TIMEOUT_CICLOS   inactivity limit in cycles (2..65535), only
//                                used when TIMEOUT_INATIVIDADE_EN is defined
//
// Build macro : TIMEOUT_INATIVIDADE_EN - when defined, a 16-bit inactivity
//               counter returns the panel to idle after TIMEOUT_CICLOS cycles
//               without an accepted press. It covers the selecting state and
//               the confirmed state before busy has been seen. When the macro
//               is undefined, no counter is built.
//
// Ports       : clock           in   system clock, rising edge
//               reset           in   asynchronous active-high reset
//               botaoAvanca     in   raw "next drink" button (async)
//               botaoConfirma   in   raw "confirm" button (async)
//               maquinaOcupada  in   brewing controller busy flag (sync)
//               saida1Contador  out  selection count MSB (registered)
//               saida2Contador  out  selection count LSB (registered)
//               escolhaCodigo   out  [1:0] last confirmed selection
//               escolhaPronta   out  one-cycle strobe: escolhaCodigo updated
//               estadoSelecao   out  [1:0] FSM state (debug)
//
// Revision    : 1.0 - initial release
// ============================================================================
module selecao_contador_bebida #(
    parameter int DEBOUNCE_CICLOS = 16,
    parameter int TIMEOUT_CICLOS  = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       botaoAvanca,
    input  logic       botaoConfirma,
    input  logic       maquinaOcupada,
    output logic       saida1Contador,
    output logic       saida2Contador,
    output logic [1:0] escolhaCodigo,
    output logic       escolhaPronta,
    output logic [1:0] estadoSelecao
);

    // FSM encoding (also the debug encoding on estadoSelecao)
    localparam logic [1:0] C_OCIOSO      = 2'b00;
    localparam logic [1:0] C_SELECIONANDO = 2'b01;
    localparam logic [1:0] C_CONFIRMADO  = 2'b10;

    localparam logic [7:0] C_DEB_LAST = 8'(DEBOUNCE_CICLOS - 1);

    // ------------------------------------------------------------------------
    // Input conditioning. Bit 0 is Avanca and bit 1 is Confirma.
    // ------------------------------------------------------------------------
    logic [1:0] w_raw;
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_deb;
    logic [1:0] r_deb_d;
    logic [7:0] r_deb_cnt [2];
    logic [1:0] w_press;

    assign w_raw = {botaoConfirma, botaoAvanca};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_deb        <= '0;
            r_deb_d      <= '0;
            r_deb_cnt[0] <= '0;
            r_deb_cnt[1] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int i = 0; i < 2; i++) begin
                // Count consecutive samples that disagree with the debounced
                // level. Any agreeing sample restarts the count.
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_deb_cnt[i] == C_DEB_LAST) begin
                        r_deb[i]     <= r_sync2[i];
                        r_deb_cnt[i] <= '0;
                    end else begin
                        r_deb_cnt[i] <= r_deb_cnt[i] + 8'd1;
                    end
                end else begin
                    r_deb_cnt[i] <= '0;
                end
            end
        end
    end

    // One-cycle press event on the debounced 0->1 transition
    assign w_press = r_deb & ~r_deb_d;

    // Presses are dropped while the brewer is busy. The debouncers keep
    // tracking the buttons regardless.
    logic w_ev_av;
    logic w_ev_cf;
    assign w_ev_av = w_press[0] & ~maquinaOcupada;
    assign w_ev_cf = w_press[1] & ~maquinaOcupada;

    // ------------------------------------------------------------------------
    // FSM state and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [1:0] r_count;
    logic [1:0] w_next_count;
    logic [1:0] r_codigo;
    logic [1:0] w_next_codigo;
    logic       r_pronta;
    logic       w_next_pronta;
    logic       r_viu;
    logic       w_next_viu;
    logic       w_timeout;

`ifdef TIMEOUT_INATIVIDADE_EN
    localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT_CICLOS - 1);

    logic [15:0] r_inativo;
    logic        w_ativo;
    logic        w_aceito;

    // Once busy has been seen in CONFIRMADO, the exit is guaranteed, so the
    // timer only guards against a brewer that never starts.
    assign w_ativo   = (r_state == C_SELECIONANDO) ||
                       ((r_state == C_CONFIRMADO) && !r_viu);
    assign w_aceito  = (r_state == C_SELECIONANDO) && (w_ev_av || w_ev_cf);
    assign w_timeout = w_ativo && !w_aceito && (r_inativo == C_TO_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inativo <= '0;
        end else if ((w_next_state != r_state) || w_aceito || !w_ativo) begin
            r_inativo <= '0;
        end else begin
            r_inativo <= r_inativo + 16'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= C_OCIOSO;
            r_count  <= '0;
            r_codigo <= '0;
            r_pronta <= 1'b0;
            r_viu    <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_count  <= w_next_count;
            r_codigo <= w_next_codigo;
            r_pronta <= w_next_pronta;
            r_viu    <= w_next_viu;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_OCIOSO: begin
                if (w_ev_av) begin
                    w_next_state = C_SELECIONANDO;
                end
            end
            C_SELECIONANDO: begin
                if (w_ev_cf) begin
                    w_next_state = C_CONFIRMADO;
                end else if (w_timeout) begin
                    w_next_state = C_OCIOSO;
                end
            end
            C_CONFIRMADO: begin
                // Return only after the brewer has been busy and released
                if (!maquinaOcupada && r_viu) begin
                    w_next_state = C_OCIOSO;
                end else if (w_timeout) begin
                    w_next_state = C_OCIOSO;
                end
            end
            default: w_next_state = C_OCIOSO;
        endcase
    end

    // Datapath / output logic
    always_comb begin
        w_next_count  = r_count;
        w_next_codigo = r_codigo;
        w_next_pronta = 1'b0;
        w_next_viu    = r_viu;
        case (r_state)
            C_OCIOSO: begin
                w_next_count = 2'b00;
            end
            C_SELECIONANDO: begin
                // Confirm has priority: the latched code is the count before
                // any simultaneous advance.
                if (w_ev_cf) begin
                    w_next_codigo = r_count;
                    w_next_pronta = 1'b1;
                end else if (w_ev_av) begin
                    w_next_count = r_count + 2'd1;
                end
            end
            C_CONFIRMADO: begin
                if (maquinaOcupada) begin
                    w_next_viu = 1'b1;
                end
            end
            default: ;
        endcase
        if (w_next_state == C_OCIOSO) begin
            w_next_count = 2'b00;
        end
        if (w_next_state != C_CONFIRMADO) begin
            w_next_viu = 1'b0;
        end
    end

    assign saida1Contador = r_count[1];
    assign saida2Contador = r_count[0];
    assign escolhaCodigo  = r_codigo;
    assign escolhaPronta  = r_pronta;
    assign estadoSelecao  = r_state;

endmodule
`default_nettype wire
